// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM block-transfer sequencer walking a 16-bit register list.
// Base register writeback (WB state) exists only when SEQ_BASE_WRITEBACK_EN is defined.
module ldm_stm_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_addr,
    input  logic        up,
    input  logic        pre,
    input  logic        writeback,
    output logic [3:0]  rb_read_select,
    input  logic [31:0] rb_read_data,
    output logic [3:0]  rb_write_select,
    output logic        rb_write_en,
    output logic [31:0] rb_write_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic        load_q, load_d, wb_q, wb_d;
    logic [3:0]  base_reg_q, base_reg_d, cur;
    logic [31:0] addr_q, addr_d, final_q, final_d, span;
    logic [4:0]  n;
    logic        wb_en, xfer, st, ld_wr, wb_wr;
`ifdef SEQ_BASE_WRITEBACK_EN
    assign wb_en = writeback;
`else
    assign wb_en = writeback & 1'b0;
`endif
    always_comb begin
        n   = '0;
        cur = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
        for (int i = 15; i >= 0; i--) if (pend_q[i]) cur = 4'(i);
    end
    assign span = {25'd0, n, 2'b00};
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        load_d     = load_q;
        wb_d       = wb_q;
        base_reg_d = base_reg_q;
        addr_d     = addr_q;
        final_d    = final_q;
        case (state_q)
            IDLE: if (start) begin
                load_d     = is_load;
                pend_d     = reg_list;
                base_reg_d = base_reg;
                // a load that includes the base register keeps the loaded value
                wb_d       = wb_en && !(is_load && reg_list[base_reg]);
                addr_d     = up ? base_addr + (pre ? 32'd4 : 32'd0)
                                : base_addr - span + (pre ? 32'd0 : 32'd4);
                final_d    = up ? base_addr + span : base_addr - span;
                state_d    = (reg_list == 16'd0) ? DONE : XFER;
            end
            XFER: if (mem_ack) begin
                pend_d = pend_q & ~(16'd1 << cur);
                addr_d = addr_q + 32'd4;
                if (pend_d == 16'd0) state_d = wb_q ? WB : DONE;
            end
            WB:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
            base_reg_q <= '0;
            addr_q     <= '0;
            final_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            load_q     <= load_d;
            wb_q       <= wb_d;
            base_reg_q <= base_reg_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
        end
    end
    assign xfer            = state_q == XFER;
    assign st              = xfer && !load_q;
    assign ld_wr           = xfer && load_q && mem_ack;
    assign wb_wr           = state_q == WB;
    assign mem_req         = xfer;
    assign mem_we          = st;
    assign mem_addr        = xfer ? addr_q : 32'd0;
    assign rb_read_select  = st ? cur : 4'd0;
    assign mem_wdata       = st ? rb_read_data : 32'd0;
    assign rb_write_en     = (ld_wr || wb_wr) && !reset;
    assign rb_write_select = ld_wr ? cur : wb_wr ? base_reg_q : 4'd0;
    assign rb_write_data   = ld_wr ? mem_rdata : wb_wr ? final_q : 32'd0;
    assign busy            = xfer || wb_wr;
    assign done            = state_q == DONE;
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: table-driven transfers plus hand sequences for ack wait, ignored start and reset.
module tb_ldm_stm_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_load = 1'b0;
    logic [15:0] reg_list = '0;
    logic [3:0]  base_reg = '0;
    logic [31:0] base_addr = '0;
    logic        up = 1'b0, pre = 1'b0, writeback = 1'b0, mem_ack = 1'b0;
    logic [3:0]  rb_read_select, rb_write_select;
    logic [31:0] rb_read_data, rb_write_data, mem_addr, mem_wdata, mem_rdata;
    logic        rb_write_en, mem_req, mem_we, busy, done;
    int          n_vec = 0, n_err = 0;
`ifdef SEQ_BASE_WRITEBACK_EN
    localparam bit WBM = 1'b1;
`else
    localparam bit WBM = 1'b0;
`endif
    localparam logic [31:0] RKEY = 32'h55AA_0000;

    ldm_stm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .reg_list(reg_list),
        .base_reg(base_reg), .base_addr(base_addr), .up(up), .pre(pre), .writeback(writeback),
        .rb_read_select(rb_read_select), .rb_read_data(rb_read_data),
        .rb_write_select(rb_write_select), .rb_write_en(rb_write_en), .rb_write_data(rb_write_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    // register Ri reads as 0xA0+i; memory returns address xor a key
    assign rb_read_data = 32'hA0 + 32'(rb_read_select);
    assign mem_rdata    = mem_addr ^ RKEY;

    typedef struct {
        logic        ld;
        logic [15:0] list;
        logic [3:0]  breg;
        logic [31:0] base;
        logic        up, pre, wb;
        logic [31:0] addr0, fin;
        logic        wb_exp;
        int          wait_c;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] p);
        lowest = 4'd0;
        for (int i = 15; i >= 0; i--) if (p[i]) lowest = 4'(i);
    endfunction

    task automatic run(input vec_t v);
        logic [15:0] pend;
        logic [3:0]  r;
        logic [31:0] ea;
        int          k, cnt, w, nreg, exp_cyc;
        bit          wbx, seen;
        pend = v.list; k = 0; cnt = 1; w = 0; seen = 1'b0;
        wbx = WBM && v.wb_exp;
        nreg = $countones(v.list);
        exp_cyc = nreg * (1 + v.wait_c) + 2 + (wbx ? 1 : 0);
        @(negedge clk);
        is_load = v.ld; reg_list = v.list; base_reg = v.breg; base_addr = v.base;
        up = v.up; pre = v.pre; writeback = v.wb; start = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cnt++;
            mem_ack = mem_req && (w == v.wait_c);
            #1;
            if (done) break;
            if (mem_req) begin
                r  = lowest(pend);
                ea = v.addr0 + 32'(4 * k);
                check("mem_addr", mem_addr, ea);
                check("mem_we", 32'(mem_we), 32'(!v.ld));
                if (!v.ld) begin
                    check("rd_sel", 32'(rb_read_select), 32'(r));
                    check("wdata", mem_wdata, 32'hA0 + 32'(r));
                end
                check("ld_wen", 32'(rb_write_en), 32'(mem_ack && v.ld));
                if (mem_ack && v.ld) begin
                    check("ld_wsel", 32'(rb_write_select), 32'(r));
                    check("ld_wdata", rb_write_data, ea ^ RKEY);
                end
                if (mem_ack) begin
                    pend[r] = 1'b0; k++; w = 0;
                end else w++;
            end else if (busy) begin
                seen = 1'b1;
                check("wb_wen", 32'(rb_write_en), 32'd1);
                check("wb_wsel", 32'(rb_write_select), 32'(v.breg));
                check("wb_wdata", rb_write_data, v.fin);
            end else check("stray_idle", 32'(busy), 32'd1);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("cycles", 32'(cnt), 32'(exp_cyc));
        check("xfers", 32'(k), 32'(nreg));
        check("wb_seen", 32'(seen), 32'(wbx));
        @(negedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        //          ld    list      breg   base           up    pre   wb    addr0          fin            wbx   wait
        tbl[0] = '{1'b0, 16'h000F, 4'd0,  32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0110, 1'b0, 0};
        tbl[1] = '{1'b1, 16'h8006, 4'd13, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'h0000_01F4, 32'h0000_01F4, 1'b1, 0};
        tbl[2] = '{1'b1, 16'h0001, 4'd0,  32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b0, 3};
        tbl[3] = '{1'b1, 16'h0004, 4'd2,  32'h0000_0300, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0304, 1'b0, 0};
        tbl[4] = '{1'b0, 16'h0101, 4'd0,  32'h0000_0040, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 32'h0000_0038, 1'b1, 0};
        tbl[5] = '{1'b0, 16'hFFFF, 4'd5,  32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4, 32'h0000_0030, 1'b1, 0};
        tbl[6] = '{1'b1, 16'h00F0, 4'd3,  32'h0000_0080, 1'b0, 1'b1, 1'b1, 32'h0000_0070, 32'h0000_0070, 1'b1, 1};
        tbl[7] = '{1'b0, 16'h0000, 4'd1,  32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0500, 1'b0, 0};
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wen", 32'(rb_write_en), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_sels", {24'd0, rb_read_select, rb_write_select}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) run(tbl[i]);

        // start while busy is ignored
        @(negedge clk);
        is_load = 1'b0; reg_list = 16'h0003; base_addr = 32'h100; up = 1'b1; pre = 1'b0;
        writeback = 1'b0; start = 1'b1;
        @(negedge clk);
        is_load = 1'b1; reg_list = 16'h0000; base_addr = 32'h900; mem_ack = 1'b0;
        #1;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_addr", mem_addr, 32'h100);
        check("ign_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        #1;
        check("ign_addr2", mem_addr, 32'h100);
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1;
        #1;
        check("ign_wdata0", mem_wdata, 32'hA0);
        @(negedge clk);
        #1;
        check("ign_addr1", mem_addr, 32'h104);
        check("ign_wdata1", mem_wdata, 32'hA1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("ign_done", 32'(done), 32'd1);
        @(negedge clk);
        #1;
        check("ign_idle", {30'd0, busy, done}, 32'd0);

        // reset during the second of four load transfers
        @(negedge clk);
        is_load = 1'b1; reg_list = 16'h000F; base_addr = 32'h100; up = 1'b1; pre = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1;
        #1;
        check("rs_wen0", 32'(rb_write_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rs_addr1", mem_addr, 32'h104);
        check("rs_wen_gated", 32'(rb_write_en), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        #1;
        check("rs_req", 32'(mem_req), 32'd0);
        check("rs_busy_done", {30'd0, busy, done}, 32'd0);
        check("rs_addr", mem_addr, 32'd0);
        check("rs_wen", 32'(rb_write_en), 32'd0);
        check("rs_wdata", rb_write_data, 32'd0);
        @(negedge clk);
        #1;
        check("rs_nodone", 32'(done), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle block-transfer initiator for the ARM core: executes LDM/STM by walking a 16-bit register list. For stores it drives register bank read selects and forwards the data to memory; for loads it forwards memory data into register bank writes. It sits between the instruction decoder and both the register bank and the memory interface, and is the master side of the bank's select/enable/data ports.

## Interface
- No parameters; data width is fixed at 32 bits and there are 16 registers.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- reg_list  in  16  bit i selects Ri
- base_reg  in  4  base register number
- base_addr  in  32  current base value, captured at start
- up  in  1  1 = increment, 0 = decrement
- pre  in  1  1 = before (IB/DB), 0 = after (IA/DA)
- writeback  in  1  request base writeback
- rb_read_select  out  4  register bank read select (store data)
- rb_read_data  in  32  combinational bank read data for rb_read_select
- rb_write_select  out  4  register bank write select
- rb_write_en  out  1  register bank write enable
- rb_write_data  out  32  register bank write data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address (bits [1:0] = 0)
- mem_wdata  out  32  store data
- mem_ack  in  1  transfer completes in the cycle it is sampled high
- mem_rdata  in  32  load data, valid while mem_ack = 1
- busy  out  1  high in XFER and WB
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE + start: capture is_load, reg_list into pending mask, base_reg, writeback, n = popcount(reg_list).
  - Start address: IA = base; IB = base+4; DA = base−4n+4; DB = base−4n.
  - Final address: up ? base+4n : base−4n, computed modulo 2^32.
  - Next state is XFER, or DONE if reg_list = 0.
- XFER: current register = lowest set bit of pending.
  - mem_req = 1, mem_addr = running address, mem_we = !is_load.
  - Store: rb_read_select = current register; mem_wdata = rb_read_data, combinational.
  - On the mem_ack cycle, for a load: rb_write_en = 1, rb_write_select = current register, rb_write_data = mem_rdata.
  - On mem_ack: clear the bit, address += 4. Lowest-numbered register always takes the lowest address.
  - When pending becomes empty, go to WB if writeback is enabled and active, else DONE.
- WB: one cycle; rb_write_en = 1, select = base_reg, data = final address.
  - WB is skipped (go straight to DONE) on a load whose list contains base_reg; the loaded value wins.
- DONE: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Loading R15 is an ordinary bank write through rb_write_select = 15.

## Timing
- Reset values: state = IDLE; mem_req, mem_we, rb_write_en, busy, done = 0; all selects, mem_addr and data outputs = 0.
- start at edge k leads to mem_req high after edge k+1.
- Each register costs 1 + (ack wait) cycles.
- Minimum total, start to done: n + 2 cycles without WB, n + 3 with WB. Empty list: done after edge k+1.
- Zero-wait memory (mem_ack tied high): one register per cycle.
- Address and data stay stable while mem_req = 1 and mem_ack = 0.
- Reset asserted mid-operation:
  - rb_write_en is gated with !reset in that cycle; any mem_ack in that cycle is discarded.
  - The edge returns the block to IDLE. No writeback and no done pulse.

## Configuration
- SEQ_BASE_WRITEBACK_EN defined: the writeback input and the WB state are implemented as described.
- SEQ_BASE_WRITEBACK_EN undefined: writeback is ignored and WB never occurs. DONE follows the last transfer directly, and the base register is never written.

## Test plan
- STM IA, reg_list = 0x000F, base = 0x100, R0..R3 = 0xA0..0xA3, mem_ack tied high -> writes 0xA0..0xA3 to 0x100/0x104/0x108/0x10C on consecutive cycles; done at cycle 6.
- LDM DB with writeback, reg_list = 0x8006, base_reg = 13, base = 0x200 -> reads R1 @0x1F4, R2 @0x1F8, R15 @0x1FC; WB writes R13 = 0x1F4.
- LDM IB, reg_list = 0x0001, mem_ack delayed 3 cycles -> mem_addr = 0x104 held for all 4 request cycles; single R0 write only in the ack cycle.
- LDM IA with writeback, base_reg = 2 in reg_list = 0x0004, mem_rdata = 0x55 -> R2 = 0x55 and no WB cycle. With the macro undefined, no WB ever occurs.
- reg_list = 0 -> no mem_req, done one cycle after start; start while busy is ignored.
- Reset asserted during the 2nd of 4 transfers while mem_ack = 1 -> no rb_write_en that cycle; IDLE with all outputs 0 next cycle; no done pulse.
